// File: rtl/blockxfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blockxfer_sequencer
// Purpose  : LDM/STM micro-op sequencer in Decode. Holds a block-transfer
//            instruction while it walks the 16-bit register list. It emits
//            one single-register micro-op per cycle (register number and byte
//            offset from Rn). An optional base-writeback micro-op follows.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            InstrD/InstrValidD - instruction in Decode and its valid flag
//            StallD/FlushD      - hazard-unit Decode stall / flush
//            SeqHoldD           - hold Fetch/Decode, suppress normal issue
//            UopValidD          - micro-op outputs valid this cycle
//            UopRegD/UopOffsetD - register and signed byte offset from Rn
//            UopLoadD           - 1 = load, 0 = store
//            UopWritebackD      - micro-op writes Rn + UopOffsetD back to Rn
//            UopLastD           - final micro-op of the instruction
// Revision : 1.0 - initial release
// ============================================================================
module blockxfer_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic        InstrValidD,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        SeqHoldD,
    output logic        UopValidD,
    output logic [3:0]  UopRegD,
    output logic [7:0]  UopOffsetD,
    output logic        UopLoadD,
    output logic        UopWritebackD,
    output logic        UopLastD
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_XFER = 2'd1;
    localparam logic [1:0] c_WB   = 2'd2;

    // Sequencer state
    logic [1:0]  r_state;
    logic [15:0] r_list;       // registers still to be emitted
    logic [3:0]  r_rn;
    logic        r_load;
    logic        r_wb_en;      // writeback micro-op follows the transfers
    logic [7:0]  r_wb_off;     // +4N or -4N
    logic [7:0]  r_next_off;   // offset of the next transfer micro-op

    // Registered micro-op outputs
    logic        r_uop_valid;
    logic [3:0]  r_uop_reg;
    logic [7:0]  r_uop_off;
    logic        r_uop_load;
    logic        r_uop_wb;
    logic        r_uop_last;

    // Instruction field decode
    logic        w_is_blk;
    logic [15:0] w_instr_list;
    logic        w_p;
    logic        w_u;
    logic        w_w;
    logic        w_l;
    logic [3:0]  w_rn;
    logic [4:0]  w_n;
    logic [7:0]  w_n4;
    logic [7:0]  w_start_off;
    logic [7:0]  w_new_wb_off;
    logic        w_new_wb_en;
    logic        w_unused_bits;

    // Sequencing
    logic        w_last_shown;
    logic        w_start_req;
    logic [15:0] w_src_list;
    logic [15:0] w_rest;
    logic [3:0]  w_pick;
    logic [7:0]  w_off_now;
    logic        w_load_now;
    logic        w_wbe_now;
    logic [1:0]  w_state_nxt;
    logic        w_emit;
    logic        w_emit_wb;

    assign w_is_blk      = InstrValidD & (InstrD[27:25] == 3'b100);
    assign w_instr_list  = InstrD[15:0];
    assign w_p           = InstrD[24];
    assign w_u           = InstrD[23];
    assign w_w           = InstrD[21];
    assign w_l           = InstrD[20];
    assign w_rn          = InstrD[19:16];
    assign w_unused_bits = ^{InstrD[31:28], InstrD[22]};

    // Population count of the incoming register list
    always_comb begin
        w_n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_n = w_n + {4'd0, w_instr_list[i]};
        end
    end

    // 4N is at most 64, so it always fits as a positive 8-bit value
    assign w_n4 = {1'b0, w_n, 2'b00};

    // Start offset for IA / IB / DA / DB addressing
    always_comb begin
        w_start_off = 8'd0;
        case ({w_p, w_u})
            2'b01:   w_start_off = 8'd0;
            2'b11:   w_start_off = 8'd4;
            2'b00:   w_start_off = 8'd4 - w_n4;
            default: w_start_off = 8'd0 - w_n4;
        endcase
    end

    assign w_new_wb_off = w_u ? w_n4 : (8'd0 - w_n4);
    // A loaded base register wins over the writeback value
    assign w_new_wb_en  = w_w & ~(w_l & w_instr_list[w_rn]);

    // While the final micro-op is on the outputs, InstrD is still the block
    // transfer that produced it; it must not be accepted a second time.
    assign w_last_shown = r_uop_valid & r_uop_last;
    assign w_start_req  = (r_state == c_IDLE) & w_is_blk & (|w_instr_list) & ~w_last_shown;

    // The first micro-op is taken straight from InstrD so that it is
    // registered at the end of the acceptance cycle.
    assign w_src_list = (r_state == c_IDLE) ? w_instr_list : r_list;
    assign w_rest     = w_src_list & (w_src_list - 16'd1);
    assign w_off_now  = (r_state == c_IDLE) ? w_start_off : r_next_off;
    assign w_load_now = (r_state == c_IDLE) ? w_l : r_load;
    assign w_wbe_now  = (r_state == c_IDLE) ? w_new_wb_en : r_wb_en;

    // Lowest set bit of the list being walked
    always_comb begin
        w_pick = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_src_list[i]) begin
                w_pick = 4'(i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_wb   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start_req && !StallD) begin
                    w_emit = 1'b1;
                end
            end
            c_XFER: begin
                if (!StallD) begin
                    w_emit = 1'b1;
                end
            end
            c_WB: begin
                if (!StallD) begin
                    w_emit_wb   = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
        if (w_emit) begin
            if (w_rest != 16'd0) begin
                w_state_nxt = c_XFER;
            end else if (w_wbe_now) begin
                w_state_nxt = c_WB;
            end else begin
                w_state_nxt = c_IDLE;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            r_state     <= c_IDLE;
            r_list      <= 16'd0;
            r_rn        <= 4'd0;
            r_load      <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_off    <= 8'd0;
            r_next_off  <= 8'd0;
            r_uop_valid <= 1'b0;
            r_uop_reg   <= 4'd0;
            r_uop_off   <= 8'd0;
            r_uop_load  <= 1'b0;
            r_uop_wb    <= 1'b0;
            r_uop_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_emit && (r_state == c_IDLE)) begin
                r_rn     <= w_rn;
                r_load   <= w_l;
                r_wb_en  <= w_new_wb_en;
                r_wb_off <= w_new_wb_off;
            end
            if (w_emit) begin
                r_list      <= w_rest;
                r_next_off  <= w_off_now + 8'd4;
                r_uop_valid <= 1'b1;
                r_uop_reg   <= w_pick;
                r_uop_off   <= w_off_now;
                r_uop_load  <= w_load_now;
                r_uop_wb    <= 1'b0;
                r_uop_last  <= (w_rest == 16'd0) & ~w_wbe_now;
            end else if (w_emit_wb) begin
                r_uop_valid <= 1'b1;
                r_uop_reg   <= r_rn;
                r_uop_off   <= r_wb_off;
                r_uop_load  <= r_load;
                r_uop_wb    <= 1'b1;
                r_uop_last  <= 1'b1;
            end else if (!StallD) begin
                r_uop_valid <= 1'b0;
                r_uop_reg   <= 4'd0;
                r_uop_off   <= 8'd0;
                r_uop_load  <= 1'b0;
                r_uop_wb    <= 1'b0;
                r_uop_last  <= 1'b0;
            end
            // StallD with nothing emitted: outputs hold and re-present
        end
    end

    assign SeqHoldD      = ~reset & (w_start_req | (r_state != c_IDLE));
    assign UopValidD     = r_uop_valid;
    assign UopRegD       = r_uop_reg;
    assign UopOffsetD    = r_uop_off;
    assign UopLoadD      = r_uop_load;
    assign UopWritebackD = r_uop_wb;
    assign UopLastD      = r_uop_last;

endmodule
`default_nettype wire

// File: tb/tb_blockxfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blockxfer_sequencer
// Purpose  : Self-checking bench for blockxfer_sequencer. Expected micro-ops
//            come from an instruction-level model and are queued. A monitor
//            compares them against every micro-op the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blockxfer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic        InstrValidD;
    logic        StallD;
    logic        FlushD;
    logic        SeqHoldD;
    logic        UopValidD;
    logic [3:0]  UopRegD;
    logic [7:0]  UopOffsetD;
    logic        UopLoadD;
    logic        UopWritebackD;
    logic        UopLastD;

    blockxfer_sequencer u_dut (
        .clk           (clk),
        .reset         (reset),
        .InstrD        (InstrD),
        .InstrValidD   (InstrValidD),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .SeqHoldD      (SeqHoldD),
        .UopValidD     (UopValidD),
        .UopRegD       (UopRegD),
        .UopOffsetD    (UopOffsetD),
        .UopLoadD      (UopLoadD),
        .UopWritebackD (UopWritebackD),
        .UopLastD      (UopLastD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rnum;
        logic [7:0] off;
        bit         load;
        bit         wb;
        bit         last;
        int         cyc;     // expected first-presentation cycle, -1 = any
    } uop_t;

    uop_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   front_seen  = 1'b0;
    uop_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int exp_cycle(input int c, input int k, input int sk, input int sl);
        if (sk == -2) return -1;
        return c + 1 + k + (((sk >= 0) && (k > sk)) ? sl : 0);
    endfunction

    // Instruction-level model: the micro-op sequence an LDM/STM implies.
    task automatic model_push(input logic [31:0] ins, input logic vld, input int c,
                              input int sk, input int sl, input int max_ops);
        logic [15:0] lst;
        int          n, base, k, rn;
        bit          p, u, w, l, dowb;
        uop_t        e;
        if (!vld || (ins[27:25] != 3'b100)) return;
        lst = ins[15:0];
        if (lst == 16'd0) return;
        n  = $countones(lst);
        p  = ins[24];
        u  = ins[23];
        w  = ins[21];
        l  = ins[20];
        rn = int'(ins[19:16]);
        if (u) base = p ? 4 : 0;
        else   base = p ? -4 * n : 4 - 4 * n;
        dowb = w && !(l && lst[rn]);
        k = 0;
        for (int r = 0; r < 16; r++) begin
            if (lst[r]) begin
                e.rnum = 4'(r);
                e.off  = 8'(base + 4 * k);
                e.load = l;
                e.wb   = 1'b0;
                e.last = (k == n - 1) && !dowb;
                e.cyc  = exp_cycle(c, k, sk, sl);
                if (k < max_ops) exp_q.push_back(e);
                k++;
            end
        end
        if (dowb && (n < max_ops)) begin
            e.rnum = 4'(rn);
            e.off  = 8'(u ? 4 * n : -4 * n);
            e.load = l;
            e.wb   = 1'b1;
            e.last = 1'b1;
            e.cyc  = exp_cycle(c, n, sk, sl);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare every presented micro-op with the queue head; it is
    // consumed only when Decode is not stalled.
    always @(negedge clk) begin
        if (UopValidD) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_uop: got reg %0d off %0d, expected no micro-op (cycle %0d)",
                         UopRegD, $signed(UopOffsetD), cyc);
            end else begin
                mon_e = exp_q[0];
                check("uop_reg",   32'(UopRegD),       32'(mon_e.rnum));
                check("uop_off",   32'(UopOffsetD),    32'(mon_e.off));
                check("uop_load",  32'(UopLoadD),      32'(mon_e.load));
                check("uop_wb",    32'(UopWritebackD), 32'(mon_e.wb));
                check("uop_last",  32'(UopLastD),      32'(mon_e.last));
                if (!reset) check("hold_vs_last", 32'(SeqHoldD), 32'(!mon_e.last));
                if (!front_seen && (mon_e.cyc >= 0)) check("uop_cycle", 32'(cyc), 32'(mon_e.cyc));
                front_seen = 1'b1;
                if (!StallD) begin
                    void'(exp_q.pop_front());
                    front_seen = 1'b0;
                end
            end
        end
    end

    // Present one instruction and emulate Decode: keep it while SeqHoldD or
    // StallD is high. sk = -1 no stall, -2 random stall, else stall sl cycles
    // starting when micro-op sk is presented.
    task automatic run_instr(input logic [31:0] ins, input logic vld, input int sk, input int sl);
        int c;
        bit done;
        bit exp_hold;
        done = 1'b0;
        @(posedge clk); #1;
        InstrD      = ins;
        InstrValidD = vld;
        c           = cyc;
        exp_hold    = vld && (ins[27:25] == 3'b100) && (ins[15:0] != 16'd0);
        model_push(ins, vld, c, sk, sl, 99);
        for (int i = 0; i < 200 && !done; i++) begin
            if (sk == -2) StallD = ($urandom_range(0, 3) == 0);
            else          StallD = (sk >= 0) && (cyc >= c + 1 + sk) && (cyc < c + 1 + sk + sl);
            @(negedge clk);
            if (i == 0) check("hold_at_accept", 32'(SeqHoldD), 32'(exp_hold));
            if (!SeqHoldD && !StallD) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) check("decode_release_timeout", 32'(done), 32'd1);
        InstrD      = 32'd0;
        InstrValidD = 1'b0;
        StallD      = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        front_seen = 1'b0;
    endtask

    // Abort a block transfer while micro-op 1 is presented: mode 0 = FlushD,
    // mode 1 = reset. Everything must read 0 on the following cycle.
    task automatic run_abort(input logic [31:0] ins, input int mode);
        int c;
        @(posedge clk); #1;
        InstrD      = ins;
        InstrValidD = 1'b1;
        StallD      = 1'b0;
        c           = cyc;
        model_push(ins, 1'b1, c, -1, 0, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (mode == 0) FlushD = 1'b1;
        else           reset  = 1'b1;
        @(posedge clk); #1;
        FlushD      = 1'b0;
        reset       = 1'b0;
        InstrD      = 32'd0;
        InstrValidD = 1'b0;
        @(negedge clk);
        check("abort_valid",  32'(UopValidD),     32'd0);
        check("abort_hold",   32'(SeqHoldD),      32'd0);
        check("abort_last",   32'(UopLastD),      32'd0);
        check("abort_wb",     32'(UopWritebackD), 32'd0);
        check("abort_reg",    32'(UopRegD),       32'd0);
        check("abort_off",    32'(UopOffsetD),    32'd0);
        check("abort_queue",  32'(exp_q.size()),  32'd0);
        exp_q.delete();
        front_seen = 1'b0;
    endtask

    initial begin
        logic [31:0] ins;
        reset       = 1'b1;
        InstrD      = 32'd0;
        InstrValidD = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold",  32'(SeqHoldD),      32'd0);
        check("rst_valid", 32'(UopValidD),     32'd0);
        check("rst_reg",   32'(UopRegD),       32'd0);
        check("rst_off",   32'(UopOffsetD),    32'd0);
        check("rst_load",  32'(UopLoadD),      32'd0);
        check("rst_wb",    32'(UopWritebackD), 32'd0);
        check("rst_last",  32'(UopLastD),      32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(32'hE890_0026, 1'b1, -1, 0);  // LDMIA r0,{r1,r2,r5}
        run_instr(32'hE92D_4010, 1'b1, -1, 0);  // STMDB sp!,{r4,lr}
        run_instr(32'hE9B3_FFFF, 1'b1,  7, 3);  // LDMIB r3!,{r0-r15}, stall at k=7
        run_instr(32'hE9A3_FFFF, 1'b1, -1, 0);  // STMIB r3!,{r0-r15}: WB +64
        run_instr(32'hE923_FFFF, 1'b1, -1, 0);  // STMDB r3!,{r0-r15}: -64
        run_instr(32'hE8B2_0006, 1'b1, -1, 0);  // LDMIA r2!,{r1,r2}: no WB
        run_instr(32'hE8A2_0006, 1'b1, -1, 0);  // STMIA r2!,{r1,r2}: WB +8
        run_instr(32'hE811_0001, 1'b1, -1, 0);  // LDMDA r1,{r0}: single op
        run_abort(32'hE806_030A, 0);            // STMDA r6,{r1,r3,r8,r9} + flush
        run_abort(32'hE806_030A, 1);            // same + reset
        run_instr(32'hE890_0000, 1'b1, -1, 0);  // LDMIA r0,{}
        run_instr(32'hE081_0002, 1'b1, -1, 0);  // ADD: not a block transfer
        run_instr(32'hE890_0026, 1'b0, -1, 0);  // bubble carrying LDM bits

        for (int t = 0; t < 150; t++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[27:25] = 3'b100;
            case ($urandom_range(0, 3))
                0:       ins[15:0] = 16'd0;
                1:       ins[15:0] = ins[15:0] & 16'($urandom) & 16'($urandom);
                default: ins[15:0] = ins[15:0] & 16'($urandom);
            endcase
            run_instr(ins, ($urandom_range(0, 7) != 0), -2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
